i2c_bus_arbiter: RTL

- Shares one i2c_controller master between NUM_REQ on-chip requesters.
- Each requester gets one single-byte I2C transaction per grant.
- Grants are round-robin. The block drives the master's addr/rw/data_in/enable inputs and watches its ready/data_out.
- Sits between the master and the register-access clients. Adds a watchdog so a hung bus cannot lock out the other requesters.

---
 rtl/i2c_bus_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master between NUM_REQ requesters,
// with a watchdog that aborts a hung transaction so other requesters are not locked out.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   m_enable,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_data_in,
  input  logic                   m_ready,
  input  logic [7:0]             m_data_out
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                m_enable_q, m_enable_d;
  logic [6:0]          m_addr_q, m_addr_d;
  logic                m_rw_q, m_rw_d;
  logic [7:0]          m_data_in_q, m_data_in_d;

  // Round-robin scan starting just after the last served requester.
  logic [IdxW-1:0] pick, cand;
  logic            pick_vld;
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  logic [6:0]         sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_rw;
  logic [NUM_REQ-1:0] pick_oh;
  assign sel_addr  = 7'(req_addr >> (7 * pick));
  assign sel_wdata = 8'(req_wdata >> (8 * pick));
  assign sel_rw    = req_rw[pick];
  assign pick_oh   = NUM_REQ'(1) << pick;

  logic wd_expired;
  assign wd_expired = (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_d        = wd_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    m_enable_d  = m_enable_q;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_in_d = m_data_in_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld && m_ready) begin
          owner_d     = pick;
          gnt_d       = pick_oh;
          m_addr_d    = sel_addr;
          m_rw_d      = sel_rw;
          m_data_in_d = sel_wdata;
          wd_d        = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        m_enable_d = 1'b1;
        wd_d       = wd_q + 1'b1;
        // Ready falling means the master latched the command; drop enable so it STOPs.
        if (!m_ready) begin
          m_enable_d = 1'b0;
          wd_d       = '0;
          state_d    = StBusy;
        end else if (wd_expired) begin
          m_enable_d = 1'b0;
          err_d      = 1'b1;
          done_d     = gnt_q;
          wd_d       = '0;
          state_d    = StDone;
        end
      end
      StBusy: begin
        wd_d = wd_q + 1'b1;
        if (m_ready) begin
          if (m_rw_q) rdata_d = m_data_out;
          done_d  = gnt_q;
          wd_d    = '0;
          state_d = StDone;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          wd_d    = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = '0;
        err_d   = 1'b0;
        gnt_d   = '0;
        last_d  = owner_q;
        wd_d    = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      last_q      <= IdxW'(NUM_REQ - 1);
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      m_enable_q  <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      m_enable_q  <= m_enable_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_in_q <= m_data_in_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign m_enable  = m_enable_q;
  assign m_addr    = m_addr_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_in_q;

endmodule
